cordic_rect_to_polar: RTL and testbench
=======================================

// Module: cordic_rect_to_polar
// PURPOSE
//  Iterative CORDIC (vectoring mode): signed (x,y) in, magnitude r and angle theta = atan2(y,x) out.
//  Parametrised successor of the fixed 8-bit rectangular-to-cylindrical converter.
//  Adds width/precision parameters, full four-quadrant angle, gain compensation, valid/ready handshakes.
//  Sits between the tile input pins and the result/output mux; one conversion in flight at a time.
// PARAMETERS
//  WIDTH   8   input x/y width, signed two's complement
//  ANG_W   16  theta width, binary angle units; 2^ANG_W = 360 deg, signed output
//  ITERS   12  CORDIC micro-rotations, 1..ANG_W
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          x_in/y_in valid
//  in_ready   out  1          block can accept; high only in IDLE
//  x_in       in   WIDTH      signed x
//  y_in       in   WIDTH      signed y
//  out_valid  out  1          r_out/theta_out valid; held until out_ready
//  out_ready  in   1          consumer accepts result
//  r_out      out  WIDTH+1    unsigned magnitude, rounded to nearest
//  theta_out  out  ANG_W      signed BAM angle; 0 = +x axis, counter-clockwise positive
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (async, any state, including mid-conversion): state=IDLE, in_ready=1, out_valid=0, r_out=0,
//    theta_out=0, busy=0, iteration counter=0. In-flight data discarded; no partial result emitted.
//  FSM: IDLE -> PRE -> ITER (ITERS cycles) -> SCALE -> DONE -> IDLE.
//  IDLE: in_valid&in_ready on an edge latches x_in/y_in; go PRE. No other state accepts input.
//  PRE (1 cycle): quadrant fold, datapath WIDTH+2 bits signed.
//    x>=0: unchanged, z=0. x<0,y>=0: (x,y)<=(y,-x), z=+90deg. x<0,y<0: (x,y)<=(-y,x), z=-90deg.
//  ITER i=0..ITERS-1 (1 cycle each): d=(y>=0); x+=d?y>>>i:-(y>>>i); y-=d?x>>>i:-(x>>>i);
//    z+=d?ATAN[i]:-ATAN[i]. Shifts arithmetic, use pre-update x/y. z wraps modulo 2^ANG_W.
//  SCALE (1 cycle): r=(x*KINV_Q16 + 2^15)>>16, KINV_Q16=39797 (0.607253). Saturate to WIDTH+1 bits.
//  DONE: out_valid=1; r_out/theta_out stable while out_ready=0. out_valid&out_ready: go IDLE,
//    out_valid=0 on next edge. in_ready rises in that same edge (no same-cycle accept in DONE).
//  Latency: acceptance edge = 0; out_valid high after edge ITERS+2. Throughput: 1 per ITERS+4 cycles min.
//  Zero input (0,0): r_out=0, theta_out=0, forced in PRE; normal latency kept.
//  Axis cases exact: (+a,0)->0; (0,+a)->+90deg; (0,-a)->-90deg; (-a,0)->-180deg (0x8000 @ANG_W=16).
//  x_in/y_in = -2^(WIDTH-1) legal; guard bits prevent overflow in PRE/ITER.
//  Accuracy: |r err|<=1 LSB; |theta err|<=4 BAM LSB at defaults.
//  in_valid while busy: ignored, in_ready=0. out_ready while not DONE: ignored.
// STRUCTURE
//  Package cordic_pkg: state enum (IDLE,PRE,ITER,SCALE,DONE); ATAN_BAM32[0:31] table
//    (atan(2^-i) in 32-bit BAM), KINV_Q16; function atan_bam(i,ANG_W) = table entry >> (32-ANG_W), rounded.
//  Sub-module cordic_stage: one combinational micro-rotation (x,y,z,i in -> x,y,z out), shared across
//    iterations by the FSM. Control FSM, counter, PRE and SCALE logic in top.
// TESTING (defaults WIDTH=8, ANG_W=16, ITERS=12)
//  (3,4) -> r=5, theta=9672+-4 (53.13deg); out_valid exactly 14 edges after accept.
//  (6,8) -> r=10, theta=9672+-4; (10,0) -> r=10, theta=0; (0,10) -> r=10, theta=16384+-4.
//  Quadrants: (-10,0) -> r=10, theta=-32768; (-5,-5) -> r=7, theta=-24576+-4 (-135deg);
//    (-128,-128) -> r=181, no overflow.
//  (0,0) -> r=0, theta=0; in_valid held high while busy -> only one acceptance; in_ready=0 until IDLE.
//  Backpressure: out_ready low 20 cycles in DONE -> outputs/out_valid stable; release -> IDLE next edge.
//  Assert rst mid-ITER -> all outputs zero, in_ready=1 immediately; next request (3,4) correct, r=5.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types, constants and the arctangent table for the rectangular-to-polar CORDIC.
// Angles are binary angle units, where a full turn equals 2^32 in the table.
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER,
        SCALE,
        DONE
    } state_e;

    localparam int KINV_Q16 = 39797;
    localparam int ITER_W   = 5;
    localparam int GUARD_W  = 2;

    localparam logic [31:0] ATAN_BAM32 [0:31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10680862,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // Table entry rescaled to ang_w bits, rounded to nearest.
    function automatic logic [31:0] atan_bam(input logic [ITER_W-1:0] i, input int ang_w);
        if (ang_w >= 32) begin
            return ATAN_BAM32[i];
        end
        return 32'(({1'b0, ATAN_BAM32[i]} + (33'd1 << (31 - ang_w))) >> (32 - ang_w));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational vectoring micro-rotation; the top reuses it for every iteration.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int DW    = 26,
    parameter int ANG_W = 16
) (
    input  logic signed [DW-1:0]     x_in,
    input  logic signed [DW-1:0]     y_in,
    input  logic        [ANG_W-1:0]  z_in,
    input  logic        [ITER_W-1:0] iter,
    output logic signed [DW-1:0]     x_out,
    output logic signed [DW-1:0]     y_out,
    output logic        [ANG_W-1:0]  z_out
);

    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;
    logic [ANG_W-1:0]     ang;

    always_comb begin
        x_sh = x_in >>> iter;
        y_sh = y_in >>> iter;
        ang  = ANG_W'(atan_bam(iter, ANG_W));
        if (y_in >= 0) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + ang;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - ang;
        end
    end

endmodule

// File: rtl/cordic_rect_to_polar.sv
// Iterative vectoring CORDIC: signed (x,y) to rounded magnitude and four-quadrant BAM angle.
//  state | meaning
//  IDLE  | waiting for a request, in_ready high
//  PRE   | quadrant fold, axis/zero angle override captured
//  ITER  | one micro-rotation per cycle, ITERS cycles
//  SCALE | gain compensation and saturation of magnitude
//  DONE  | result held until out_ready
module cordic_rect_to_polar
    import cordic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ANG_W = 16,
    parameter int ITERS = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH:0]   r_out,
    output logic signed [ANG_W-1:0] theta_out,
    output logic                    busy
);

    // Fractional bits keep small-magnitude inputs accurate in angle.
    localparam int FRAC = ANG_W;
    localparam int DW   = WIDTH + GUARD_W + FRAC;
    localparam int RW   = WIDTH + 1;
    localparam int PW   = DW + 18;

    localparam logic [ANG_W-1:0]     ANG_90  = ANG_W'(1) << (ANG_W - 2);
    localparam logic [ANG_W-1:0]     ANG_180 = ANG_W'(1) << (ANG_W - 1);
    localparam logic signed [PW-1:0] KINV    = PW'(KINV_Q16);
    localparam logic signed [PW-1:0] HALF    = {{(PW-1){1'b0}}, 1'b1} << (15 + FRAC);
    localparam logic signed [PW-1:0] RMAX    = {{(PW-RW){1'b0}}, {RW{1'b1}}};

    state_e               state_q, state_d;
    logic [ITER_W-1:0]    cnt_q, cnt_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic [ANG_W-1:0]     z_q, z_d;
    logic                 ovr_q, ovr_d;
    logic [ANG_W-1:0]     ovr_ang_q, ovr_ang_d;
    logic [RW-1:0]        r_q, r_d;
    logic [ANG_W-1:0]     theta_q, theta_d;

    logic signed [DW-1:0] x_rot, y_rot;
    logic [ANG_W-1:0]     z_rot;
    logic signed [PW-1:0] x_ext, prod, rnd;
    logic                 last_iter;

    cordic_stage #(
        .DW    (DW),
        .ANG_W (ANG_W)
    ) u_stage (
        .x_in  (x_q),
        .y_in  (y_q),
        .z_in  (z_q),
        .iter  (cnt_q),
        .x_out (x_rot),
        .y_out (y_rot),
        .z_out (z_rot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            ovr_q     <= 1'b0;
            ovr_ang_q <= '0;
            r_q       <= '0;
            theta_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            ovr_q     <= ovr_d;
            ovr_ang_q <= ovr_ang_d;
            r_q       <= r_d;
            theta_q   <= theta_d;
        end
    end

    assign last_iter = (cnt_q == ITER_W'(ITERS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = PRE;
            PRE:     state_d = ITER;
            ITER:    if (last_iter) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        ovr_d     = ovr_q;
        ovr_ang_d = ovr_ang_q;
        r_d       = r_q;
        theta_d   = theta_q;
        x_ext     = PW'(x_q);
        prod      = x_ext * KINV;
        rnd       = (prod + HALF) >>> (16 + FRAC);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d = {{GUARD_W{x_in[WIDTH-1]}}, x_in, {FRAC{1'b0}}};
                    y_d = {{GUARD_W{y_in[WIDTH-1]}}, y_in, {FRAC{1'b0}}};
                end
            end
            PRE: begin
                cnt_d     = '0;
                z_d       = '0;
                ovr_d     = 1'b0;
                ovr_ang_d = '0;
                if (x_q < 0) begin
                    if (y_q >= 0) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = ANG_90;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = -ANG_90;
                    end
                end
                // Axis inputs (and zero) get an exact angle instead of the converged one.
                if (y_q == '0) begin
                    ovr_d     = 1'b1;
                    ovr_ang_d = (x_q < 0) ? ANG_180 : '0;
                end else if (x_q == '0) begin
                    ovr_d     = 1'b1;
                    ovr_ang_d = (y_q < 0) ? -ANG_90 : ANG_90;
                end
            end
            ITER: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + 1'b1;
            end
            SCALE: begin
                if (rnd < 0) begin
                    r_d = '0;
                end else if (rnd > RMAX) begin
                    r_d = '1;
                end else begin
                    r_d = rnd[RW-1:0];
                end
                theta_d = ovr_q ? ovr_ang_q : z_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    assign r_out     = r_q;
    assign theta_out = theta_q;

endmodule

// File: tb/tb_cordic_rect_to_polar.sv
// Bench for cordic_rect_to_polar: directed corner vectors plus random vectors against a real-arithmetic model.
module tb_cordic_rect_to_polar;

    localparam int  WIDTH = 8;
    localparam int  ANG_W = 16;
    localparam int  ITERS = 12;
    localparam real PI    = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic        [WIDTH:0]   r_out;
    logic signed [ANG_W-1:0] theta_out;
    logic                    busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int acc_cnt      = 0;

    always #5 clk = ~clk;

    cordic_rect_to_polar #(
        .WIDTH (WIDTH),
        .ANG_W (ANG_W),
        .ITERS (ITERS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .theta_out (theta_out),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp, input int tol);
        tests_run++;
        if (got > exp + tol || got < exp - tol) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int wrap_bam(input int v);
        int m;
        int w;
        m = 1 << ANG_W;
        w = v % m;
        if (w < 0) w += m;
        if (w >= m / 2) w -= m;
        return w;
    endfunction

    function automatic int model_r(input int x, input int y);
        real m;
        m = $sqrt(real'(x * x + y * y));
        return int'($floor(m + 0.5));
    endfunction

    function automatic int model_th(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x));
        return wrap_bam(int'($floor(a * real'(1 << (ANG_W - 1)) / PI + 0.5)));
    endfunction

    task automatic run_one(input string tag, input int x, input int y, input int r_tol,
                           input int th_tol, input int hold, input bit keep_valid,
                           input bit check_lat);
        int exp_r;
        int exp_th;
        int lat;
        int n;
        int acc0;
        exp_r  = model_r(x, y);
        exp_th = model_th(x, y);
        @(negedge clk);
        x_in     = WIDTH'(x);
        y_in     = WIDTH'(y);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc0 = acc_cnt;
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (check_lat) check({tag, "_latency"}, lat, ITERS + 2, 0);
        else if (lat >= 100) check({tag, "_timeout"}, lat, ITERS + 2, 0);
        check({tag, "_r"}, int'(r_out), exp_r, r_tol);
        check({tag, "_theta_err"}, wrap_bam(int'(theta_out) - exp_th), 0, th_tol);
        if (keep_valid) begin
            check({tag, "_in_ready_busy"}, int'(in_ready), 0, 0);
            check({tag, "_accepts"}, acc_cnt - acc0, 1, 0);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, int'(out_valid), 1, 0);
            check({tag, "_hold_r"}, int'(r_out), exp_r, r_tol);
            check({tag, "_hold_theta"}, wrap_bam(int'(theta_out) - exp_th), 0, th_tol);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        // 1 means in_ready high and out_valid low after the release edge.
        check({tag, "_release"}, int'(in_ready) + 2 * int'(out_valid), 1, 0);
    endtask

    int dir_x   [11] = '{3, 6, 10, 0, 0, -10, -5, -128, 0, -128, 127};
    int dir_y   [11] = '{4, 8, 0, 10, -10, 0, -5, -128, 0, 0, -128};
    int dir_rt  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int dir_tt  [11] = '{4, 4, 0, 0, 0, 0, 4, 4, 0, 0, 6};
    int dir_hold[11] = '{0, 20, 0, 1, 0, 0, 2, 0, 0, 0, 0};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_r", int'(r_out), 0, 0);
        check("rst_theta", int'(theta_out), 0, 0);
        rst = 1'b0;

        run_one("v3_4_held", 3, 4, 0, 4, 0, 1'b1, 1'b1);
        for (int k = 0; k < 11; k++) begin
            run_one($sformatf("dir%0d", k), dir_x[k], dir_y[k], dir_rt[k], dir_tt[k],
                    dir_hold[k], 1'b0, 1'b1);
        end

        // Reset in the middle of the micro-rotations.
        @(negedge clk);
        x_in     = 8'sd50;
        y_in     = -8'sd30;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", int'(busy), 1, 0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1, 0);
        check("mid_rst_out_valid", int'(out_valid), 0, 0);
        check("mid_rst_busy", int'(busy), 0, 0);
        check("mid_rst_r", int'(r_out), 0, 0);
        check("mid_rst_theta", int'(theta_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_one("after_rst", 3, 4, 0, 4, 0, 1'b0, 1'b1);

        // Random vectors; angle tolerance covers the last micro-rotation residual plus table rounding.
        for (int k = 0; k < 40; k++) begin
            run_one($sformatf("rnd%0d", k), int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128, 1, 6,
                    int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
